// File: rtl/seg7_pkg.sv
// Shared types, glyph constants and BCD-to-segment decode for the 7-segment scan driver.
// Segment vectors are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_DASH  = 7'b0111111;
  localparam seg_t SEG_BLANK = 7'b1111111;

  function automatic seg_t bcd_to_seg(input logic [3:0] code);
    seg_t seg;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit decoder with blank override; non-BCD codes render as a dash.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] i_code,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = i_blank ? SEG_BLANK : bcd_to_seg(i_code);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode scanner: per-frame digit snapshot, leading-zero blanking,
// all-off guard at the start of every slot, fully registered outputs.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [4*NUM_DIGITS-1:0] i_digits,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic                    i_blank_lz,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic                    o_frame
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_dig_q, snap_dig_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    frame_q, frame_d;

  logic       frame_start;
  logic       active;
  logic [3:0] sel_code;
  logic       sel_dp;
  logic       sel_blank;
  logic       all_zero;
  logic [6:0] dec_seg;

  always_comb begin
    frame_start = (cnt_q == '0) && (idx_q == '0);
    active      = (cnt_q >= GUARD_C);

    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    snap_dig_d = frame_start ? i_digits : snap_dig_q;
    snap_dp_d  = frame_start ? i_dp     : snap_dp_q;
    frame_d    = frame_start;
  end

  // Walk from the most significant digit down so all_zero means "this digit and all above are 0".
  always_comb begin
    all_zero  = 1'b1;
    sel_code  = '0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero = all_zero && (snap_dig_q[4*k +: 4] == 4'd0);
      if (idx_q == IW'(k)) begin
        sel_code  = snap_dig_q[4*k +: 4];
        sel_dp    = snap_dp_q[k];
        sel_blank = i_blank_lz && (k != 0) && all_zero;
      end
    end
  end

  seg7_decoder u_decoder (
    .i_code  (sel_code),
    .i_blank (sel_blank),
    .o_seg   (dec_seg)
  );

  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (active) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        an_d[k] = (idx_q != IW'(k));
      end
      seg_d = dec_seg;
      dp_d  = ~sel_dp;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      snap_dig_q <= '0;
      snap_dp_q  <= '0;
      an_q       <= '1;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
      frame_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      snap_dig_q <= snap_dig_d;
      snap_dp_q  <= snap_dp_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      frame_q    <= frame_d;
    end
  end

  assign o_an    = an_q;
  assign o_seg   = seg_q;
  assign o_dp    = dp_q;
  assign o_frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: every cycle is compared against a time-indexed frame model.
module tb_seg7_scan_driver;

  localparam int N     = 4;
  localparam int R     = 8;
  localparam int G     = 2;
  localparam int FRAME = N * R;

  logic          clk = 1'b0;
  logic          i_rst;
  logic [15:0]   i_digits;
  logic [3:0]    i_dp;
  logic          i_blank_lz;
  logic [3:0]    o_an;
  logic [6:0]    o_seg;
  logic          o_dp;
  logic          o_frame;

  int checks = 0;
  int errors = 0;

  // Model state: edges since reset release and the digits captured at the last frame start.
  int          t = 0;
  logic [15:0] m_dig = '0;
  logic [3:0]  m_dp  = '0;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic        exp_frame;

  seg7_scan_driver #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (R),
    .GUARD       (G)
  ) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_digits   (i_digits),
    .i_dp       (i_dp),
    .i_blank_lz (i_blank_lz),
    .o_an       (o_an),
    .o_seg      (o_seg),
    .o_dp       (o_dp),
    .o_frame    (o_frame)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'd0: g = 7'b1000000;
      4'd1: g = 7'b1111001;
      4'd2: g = 7'b0100100;
      4'd3: g = 7'b0110000;
      4'd4: g = 7'b0011001;
      4'd5: g = 7'b0010010;
      4'd6: g = 7'b0000010;
      4'd7: g = 7'b1111000;
      4'd8: g = 7'b0000000;
      4'd9: g = 7'b0010000;
      default: g = 7'b0111111;
    endcase
    return g;
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, expv);
    end
  endtask

  task automatic tick();
    logic        rst_s;
    logic [15:0] dig_s;
    logic [3:0]  dp_s;
    logic        blz_s;
    logic [15:0] upper;
    int          p;
    int          slot;
    int          c;
    rst_s = i_rst;
    dig_s = i_digits;
    dp_s  = i_dp;
    blz_s = i_blank_lz;
    @(posedge clk);
    if (rst_s) begin
      t         = 0;
      m_dig     = '0;
      m_dp      = '0;
      exp_an    = 4'hF;
      exp_seg   = 7'h7F;
      exp_dp    = 1'b1;
      exp_frame = 1'b0;
    end else begin
      p    = t % FRAME;
      slot = p / R;
      c    = p % R;
      if (p == 0) begin
        m_dig = dig_s;
        m_dp  = dp_s;
      end
      exp_frame = (p == 0);
      if (c < G) begin
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
        exp_dp  = 1'b1;
      end else begin
        exp_an  = ~(4'b0001 << slot);
        upper   = m_dig >> (4 * slot);
        exp_seg = (blz_s && slot > 0 && upper == 16'h0) ? 7'h7F : glyph(upper[3:0]);
        exp_dp  = ~m_dp[slot];
      end
      t++;
    end
    #1;
    chk("an",    {3'b000, o_an},      {3'b000, exp_an});
    chk("seg",   o_seg,               exp_seg);
    chk("dp",    {6'b0, o_dp},        {6'b0, exp_dp});
    chk("frame", {6'b0, o_frame},     {6'b0, exp_frame});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    i_rst      = 1'b1;
    i_digits   = 16'h1234;
    i_dp       = 4'b0000;
    i_blank_lz = 1'b0;

    // Reset state, then plain scan of 1234
    run(3);
    i_rst = 1'b0;
    run(2 * FRAME);

    // Reset held for 3 cycles in the middle of a slot
    run(11);
    i_rst = 1'b1;
    run(3);
    i_rst = 1'b0;
    run(FRAME);

    // Invalid code renders as dash
    i_digits = 16'h00A0;
    run(2 * FRAME);

    // Leading-zero blanking
    i_digits   = 16'h0050;
    i_blank_lz = 1'b1;
    run(2 * FRAME);
    i_digits = 16'h0000;
    run(2 * FRAME);

    // Snapshot coherency: change input during slot 2
    i_digits   = 16'h1234;
    i_blank_lz = 1'b0;
    run(FRAME);
    while ((t % FRAME) != 2 * R + 1) tick();
    i_digits = 16'h5678;
    run(2 * FRAME);

    // Decimal point on digit 2
    i_dp = 4'b0100;
    run(2 * FRAME);

    // Randomized inputs changing at arbitrary times, with one reset mid-run
    for (int i = 0; i < 20 * FRAME; i++) begin
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(3))
          0: i_digits = 16'($urandom) & 16'hFFFF;
          1: i_digits = 16'($urandom) & 16'h00FF;
          2: i_digits = 16'($urandom) & 16'h000F;
          default: i_digits = 16'($urandom) & 16'h0F0F;
        endcase
        i_dp       = 4'($urandom);
        i_blank_lz = 1'($urandom);
      end
      i_rst = (i >= 300 && i < 302);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
